// File: rtl/apb_requester_if.sv
// rtl/apb_requester_if.sv - command/response and APB signal bundle for apb_requester
interface apb_requester_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - single-beat APB initiator with wait-state timeout
module apb_requester #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic               pclk,
    input  logic               preset,
    apb_requester_if.master    bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            done;
    logic            abort;

    assign bus.cmd_ready = (state == IDLE);
    assign cnt_inc       = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // pready is checked before the timeout so a completion on the last allowed cycle wins
    always_comb begin
        next_state = state;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) next_state = SETUP;
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_inc == TO_VAL)) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.pwrite    <= 1'b0;
            bus.paddr     <= '0;
            bus.pwdata    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_error <= 1'b0;
            cnt           <= '0;
        end else begin
            bus.psel      <= (next_state != IDLE);
            bus.penable   <= (next_state == ACCESS);
            bus.rsp_valid <= done | abort;
            if (state == IDLE && bus.cmd_valid) begin
                bus.pwrite <= bus.cmd_write;
                bus.paddr  <= bus.cmd_addr;
                bus.pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
                cnt        <= '0;
            end
            if (state == ACCESS && !bus.pready) begin
                cnt <= cnt_inc;
            end
            if (done) begin
                bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
                bus.rsp_error <= 1'b0;
            end else if (abort) begin
                bus.rsp_rdata <= '0;
                bus.rsp_error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - self-checking bench for apb_requester with a completer and reference model
module tb_apb_requester;
    localparam int AW      = 2;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    logic pclk;
    logic preset;
    int   checks;
    int   errors;

    logic [DW-1:0] comp_mem [0:3];
    logic [DW-1:0] ref_mem  [0:3];

    apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus.master)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // completer register file; data_size keeps only 5 bits
    always @(posedge pclk) begin
        if (bus.psel && bus.penable && bus.pready && bus.pwrite)
            comp_mem[bus.paddr] <= (bus.paddr == 2'd2) ? (bus.pwdata & 8'h1F) : bus.pwdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command through the bus; the completer raises pready on ACCESS cycle waits+1.
    task automatic do_cmd(input string tag, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int waits, input bit use_mem,
                          input logic [DW-1:0] rd_force);
        int            n_acc;
        int            guard;
        bit            exp_err;
        int            exp_acc;
        logic [DW-1:0] exp_rd;
        exp_err = (TIMEOUT != 0) && (waits >= TIMEOUT);
        exp_acc = exp_err ? TIMEOUT : waits + 1;
        exp_rd  = (wr || exp_err) ? 8'h00 : (use_mem ? ref_mem[addr] : rd_force);
        if (wr && !exp_err) ref_mem[addr] = (addr == 2'd2) ? (wd & 8'h1F) : wd;

        @(negedge pclk);
        check({tag, ".ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.pready    = 1'b0;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        check({tag, ".setup"}, {30'd0, bus.psel, bus.penable}, 32'd2);
        check({tag, ".setup_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
        n_acc = 0;
        guard = 0;
        forever begin
            @(negedge pclk);
            guard++;
            if (!(bus.psel && bus.penable) || guard > 40) break;
            n_acc++;
            if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== (wr ? wd : 8'h00))
                check({tag, ".stable"}, {21'd0, bus.paddr, bus.pwrite, bus.pwdata}, {21'd0, addr, wr, (wr ? wd : 8'h00)});
            bus.pready = (n_acc == waits + 1);
            bus.prdata = use_mem ? comp_mem[addr] : rd_force;
        end
        bus.pready = 1'b0;
        check({tag, ".access_cycles"}, n_acc, exp_acc);
        check({tag, ".rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, ".idle_psel"}, {30'd0, bus.psel, bus.penable}, 32'd0);
        check({tag, ".rsp_error"}, {31'd0, bus.rsp_error}, {31'd0, exp_err});
        check({tag, ".rsp_rdata"}, {24'd0, bus.rsp_rdata}, {24'd0, exp_rd});
        @(negedge pclk);
        check({tag, ".rsp_pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    logic [AW-1:0] b2b_addr [0:2];
    logic [DW-1:0] b2b_data [0:2];
    int            acc_cyc  [0:2];
    int            nacc;
    int            nrsp;
    bit            acc_prev;
    int            guard;

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 4; i++) begin
            comp_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        preset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;

        // reset values
        #12;
        check("rst.cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst.apb", {20'd0, bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 32'd0);
        check("rst.rsp", {22'd0, bus.rsp_valid, bus.rsp_error, bus.rsp_rdata}, 32'd0);
        @(negedge pclk);
        preset = 1'b0;

        do_cmd("wr0wait", 1'b1, 2'd1, 8'hA5, 0, 1'b0, 8'h00);
        check("wr0wait.payload_1", {24'd0, comp_mem[1]}, 32'h0000_00A5);

        do_cmd("rdwait", 1'b0, 2'd2, 8'h77, 3, 1'b0, 8'h13);

        do_cmd("timeout", 1'b1, 2'd0, 8'h3C, TIMEOUT, 1'b0, 8'h00);
        check("timeout.no_write", {24'd0, comp_mem[0]}, 32'd0);
        do_cmd("after_to", 1'b0, 2'd1, 8'h00, 1, 1'b1, 8'h00);

        do_cmd("to_edge", 1'b0, 2'd1, 8'h00, TIMEOUT - 1, 1'b0, 8'h5E);

        // back-to-back with cmd_valid held
        b2b_addr[0] = 2'd0; b2b_data[0] = 8'h11;
        b2b_addr[1] = 2'd1; b2b_data[1] = 8'h22;
        b2b_addr[2] = 2'd2; b2b_data[2] = 8'h1F;
        nacc = 0;
        nrsp = 0;
        acc_prev = 1'b0;
        @(negedge pclk);
        bus.pready    = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = b2b_addr[0];
        bus.cmd_wdata = b2b_data[0];
        for (int c = 0; c < 20; c++) begin
            if (acc_prev) begin
                if (nacc < 3) begin
                    bus.cmd_addr  = b2b_addr[nacc];
                    bus.cmd_wdata = b2b_data[nacc];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
            if (bus.rsp_valid) nrsp++;
            acc_prev = 1'b0;
            if (nacc < 3 && bus.cmd_valid && bus.cmd_ready) begin
                acc_cyc[nacc] = c;
                nacc++;
                acc_prev = 1'b1;
            end
            @(negedge pclk);
        end
        bus.pready    = 1'b0;
        bus.cmd_valid = 1'b0;
        ref_mem[0] = 8'h11;
        ref_mem[1] = 8'h22;
        ref_mem[2] = 8'h1F;
        check("b2b.accepts", nacc, 3);
        check("b2b.gap1", acc_cyc[1] - acc_cyc[0], 3);
        check("b2b.gap2", acc_cyc[2] - acc_cyc[1], 3);
        check("b2b.responses", nrsp, 3);
        check("b2b.payload_0", {24'd0, comp_mem[0]}, 32'h11);
        check("b2b.payload_1", {24'd0, comp_mem[1]}, 32'h22);
        check("b2b.data_size", {24'd0, comp_mem[2]}, 32'h1F);

        // randomized commands against the reference model
        for (int i = 0; i < 25; i++) begin
            logic          rw;
            logic [AW-1:0] ra;
            logic [DW-1:0] rd;
            int            rwaits;
            rw     = 1'($urandom_range(0, 1));
            ra     = AW'($urandom_range(0, 2));
            rd     = DW'($urandom);
            rwaits = (i % 6 == 5) ? $urandom_range(TIMEOUT, TIMEOUT + 2) : $urandom_range(0, 4);
            do_cmd($sformatf("rnd%0d", i), rw, ra, rd, rwaits, 1'b1, 8'h00);
        end
        for (int i = 0; i < 3; i++)
            check($sformatf("rnd.mem%0d", i), {24'd0, comp_mem[i]}, {24'd0, ref_mem[i]});

        // reset asserted mid-ACCESS
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 2'd1;
        bus.cmd_wdata = 8'h5A;
        bus.pready    = 1'b0;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        guard = 0;
        while (!(bus.psel && bus.penable) && guard < 10) begin
            @(negedge pclk);
            guard++;
        end
        check("midrst.in_access", {30'd0, bus.psel, bus.penable}, 32'd3);
        preset = 1'b1;
        #1;
        check("midrst.apb", {20'd0, bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 32'd0);
        check("midrst.cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge pclk);
        preset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check("postrst.idle", {29'd0, bus.cmd_ready, bus.rsp_valid, bus.psel}, 32'd4);
        end
        check("postrst.payload_1", {24'd0, comp_mem[1]}, {24'd0, ref_mem[1]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
